string_fifo_scan_avalon: RTL and testbench
==========================================

# string_fifo_scan_avalon

Parametrised Avalon-MM slave string FIFO for the NIOS II string accelerator. Software pushes packed 4-character words, pops them back in order, and can launch a non-destructive hardware scan. The scan reports string length, up to the first NUL, and the character index of the first occurrence of a key byte. It adds configurable depth, sticky error flags, occupancy count and the scan engine on top of the original fixed 4-entry string queue.

## Interface
- DEPTH, 16: FIFO entries of 32 bits; a power of two, 2..256.
- AW, $clog2(DEPTH): pointer width (derived; do not override).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- writedata  in  32  write data; character 0 is [31:24], character 3 is [7:0].
- address  in  3  word register select.
- readdata  out  32  registered read data.
- write  in  1  write strobe, qualified by chipselect.
- read  in  1  read strobe, qualified by chipselect.
- chipselect  in  1  slave select.

## Operation
- Register map:
  - 0 DATA: write pushes; read pops the head word.
  - 1 STATUS (RO): [0] empty, [1] full, [2] overflow, [3] underflow, [4] busy, [5] match, [6] busy_err, [16+AW:16] count.
  - 2 CONTROL (WO, self-clearing): [0] clear FIFO, [1] start scan, [2] clear sticky bits [3:2] and [6], [3] casefold (see Configuration).
  - 3 KEY (RW): [7:0] search byte.
  - 4 RESULT (RO): character index of the first KEY match, else 0xFFFFFFFF.
  - 5 STRLEN (RO): characters before the first NUL, else 4×count.
  - 6–7: reserved; read 0, writes ignored.
- Access counting: each cycle with chipselect&write is one write access, and each cycle with chipselect&read is one read access. A read held for 2 cycles on DATA pops twice.
- Write and read in the same cycle: the write is performed, readdata=0 and no pop occurs.
- Push when full: data is dropped and overflow is set. Pop when empty: readdata=0 and underflow is set.
- DATA access while busy: no push or pop, busy_err is set, and a read returns 0.
- Scan FSM:
  - IDLE→SCAN on start when not busy; start while busy is ignored.
  - SCAN reads word (head+i) mod DEPTH each cycle without moving the pointers.
  - Bytes are checked in order 0..3. The first KEY match sets RESULT=4i+b and match=1. The first NUL sets STRLEN=4i+b and ends the scan after the current word.
  - Bytes after the NUL are never matched. KEY=0x00 therefore matches the terminator itself.
  - If no NUL is found, the scan ends after `count` words with STRLEN=4×count.
  - SCAN→DONE→IDLE. Start with count=0 goes directly to DONE: RESULT=0xFFFFFFFF, STRLEN=0.
  - Start clears match and resets RESULT to all-ones before scanning.
- Clear: pointers and count go to 0. Any scan is aborted to IDLE with RESULT=0xFFFFFFFF, STRLEN=0, match=0. Sticky flags are kept.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and needs AW+1 bits.

## Timing
- Reset values: readdata=0, pointers=0, count=0, KEY=0, STRLEN=0, RESULT=0xFFFFFFFF, all flags 0, FSM=IDLE.
- Read latency is 1: readdata is valid the cycle after the read is sampled. The pop takes effect in the sampled cycle.
- Push is visible in count and STATUS on the next cycle.
- Scan started in cycle T: busy=1 from T+1. Word i is examined at T+1+i. For n words scanned, DONE occurs at T+1+n and busy=0 with results valid from T+2+n.
- A STATUS read in the same cycle as a state change returns the pre-change value.

## Configuration
- STRFIFO_CASEFOLD_EN defined: CONTROL[3] is a stored mode bit, readable at STATUS[7]. When it is 1, the KEY comparison treats 'A'–'Z' and 'a'–'z' as equal. The NUL check is unaffected.
- STRFIFO_CASEFOLD_EN not defined: CONTROL[3] is ignored, STATUS[7] reads 0 and the comparison is exact.

## Test plan
- After reset, push "abcd","1234","5678", then read DATA 3 times → readdata "abcd","1234","5678"; STATUS.empty=1, count=0.
- DEPTH=4: push 5 words → 5th dropped and overflow=1. Pop 5 → 5th returns 0 and underflow=1. Write CONTROL=0x4 → both clear.
- Push "hell","o\0xy", KEY='o', start → RESULT=4, STRLEN=5, match=1, busy high for 3 cycles. The FIFO still holds 2 words.
- Push "abcd" only, KEY='z', start → RESULT=0xFFFFFFFF, STRLEN=4, match=0. KEY=0x00 on the same data → RESULT=0xFFFFFFFF.
- Hold read high 2 cycles on DATA with 2 words queued → both pop. A DATA read during a scan → returns 0, busy_err=1, count unchanged.
- Wrap-around and abort, DEPTH=4:
  - Push 3, pop 2, push 3 (pointers wrap), start scan → words scanned in FIFO order.
  - Clear mid-scan → FSM returns to IDLE, RESULT=0xFFFFFFFF, count=0.
  - With STRFIFO_CASEFOLD_EN and CONTROL[3]=1: "ABcd" with KEY='b' → RESULT=1.

Source files
------------

// File: rtl/string_fifo_scan_avalon_if.sv
// Avalon-MM slave bus bundle for the string FIFO accelerator.
interface string_fifo_scan_avalon_if;
  logic [31:0] writedata;
  logic [2:0]  address;
  logic [31:0] readdata;
  logic        write;
  logic        read;
  logic        chipselect;

  modport master (output writedata, address, write, read, chipselect, input readdata);
  modport slave  (input writedata, address, write, read, chipselect, output readdata);
endinterface

// File: rtl/string_fifo_scan_avalon.sv
// Avalon-MM string FIFO with non-destructive NUL/key scan engine.
// Optional STRFIFO_CASEFOLD_EN: CONTROL[3] stores a case-insensitive KEY compare mode.
module string_fifo_scan_avalon #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic                      clk,
  input logic                      reset,
  string_fifo_scan_avalon_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, scan_addr;
  logic [AW:0]   count_q, count_d, idx_q, idx_d;
  logic [31:0]   readdata_q, readdata_d, result_q, result_d, strlen_q, strlen_d;
  logic [31:0]   status, scan_word, base;
  logic [7:0]    key_q, key_d, ch;
  logic          ovf_q, ovf_d, udf_q, udf_d, berr_q, berr_d, match_q, match_d;
  logic          cf_q, cf_d;
  logic          wr_acc, rd_acc, busy, empty, full, push, nul_hit, hit_found;

  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
  endfunction

  function automatic logic key_eq(input logic [7:0] c, input logic [7:0] k, input logic cf);
    return cf ? (fold(c) == fold(k)) : (c == k);
  endfunction

  assign wr_acc    = bus.chipselect & bus.write;
  assign rd_acc    = bus.chipselect & bus.read;
  assign busy      = (state_q != S_IDLE);
  assign empty     = (count_q == '0);
  assign full      = count_q[AW];
  assign scan_addr = rd_ptr_q + idx_q[AW-1:0];
  assign scan_word = mem_q[scan_addr];
  assign base      = 32'(idx_q) << 2;
  assign bus.readdata = readdata_q;

  always_comb begin
    status = '0;
    status[0] = empty;
    status[1] = full;
    status[2] = ovf_q;
    status[3] = udf_q;
    status[4] = busy;
    status[5] = match_q;
    status[6] = berr_q;
    status[7] = cf_q;
    status[16+AW:16] = count_q;
  end

  always_comb begin
    state_d = state_q;   rd_ptr_d = rd_ptr_q;   wr_ptr_d = wr_ptr_q;
    count_d = count_q;   idx_d = idx_q;         readdata_d = readdata_q;
    result_d = result_q; strlen_d = strlen_q;   key_d = key_q;
    ovf_d = ovf_q;       udf_d = udf_q;         berr_d = berr_q;
    match_d = match_q;   cf_d = cf_q;           push = 1'b0;
    nul_hit = 1'b0;      hit_found = match_q;   ch = '0;

    unique case (state_q)
      S_SCAN: begin
        // Key test precedes the NUL test so KEY=0x00 hits the terminator itself.
        for (int unsigned b = 0; b < 4; b++) begin
          ch = 8'(scan_word >> (8 * (3 - b)));
          if (!nul_hit) begin
            if (!hit_found && key_eq(ch, key_q, cf_q)) begin
              hit_found = 1'b1;
              match_d   = 1'b1;
              result_d  = base + b;
            end
            if (ch == 8'h00) begin
              nul_hit  = 1'b1;
              strlen_d = base + b;
            end
          end
        end
        idx_d = idx_q + 1'b1;
        if (nul_hit) begin
          state_d = S_DONE;
        end else if (idx_q + 1'b1 == count_q) begin
          state_d  = S_DONE;
          strlen_d = 32'(count_q) << 2;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    if (wr_acc) begin
      unique case (bus.address)
        3'd0: begin
          if (busy) berr_d = 1'b1;
          else if (full) ovf_d = 1'b1;
          else begin
            push     = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
        3'd2: begin
          if (bus.writedata[1] && !busy) begin
            match_d  = 1'b0;
            result_d = '1;
            idx_d    = '0;
            if (empty) begin
              state_d  = S_DONE;
              strlen_d = '0;
            end else begin
              state_d = S_SCAN;
            end
          end
          if (bus.writedata[2]) begin
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
            berr_d = 1'b0;
          end
`ifdef STRFIFO_CASEFOLD_EN
          cf_d = bus.writedata[3];
`endif
          // Clear is applied last so it overrides both a concurrent start and scan progress.
          if (bus.writedata[0]) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            idx_d    = '0;
            state_d  = S_IDLE;
            result_d = '1;
            strlen_d = '0;
            match_d  = 1'b0;
          end
        end
        3'd3:    key_d = bus.writedata[7:0];
        default: ;
      endcase
    end else if (rd_acc) begin
      unique case (bus.address)
        3'd0: begin
          readdata_d = '0;
          if (busy) berr_d = 1'b1;
          else if (empty) udf_d = 1'b1;
          else begin
            readdata_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
          end
        end
        3'd1:    readdata_d = status;
        3'd3:    readdata_d = {24'h0, key_q};
        3'd4:    readdata_d = result_q;
        3'd5:    readdata_d = strlen_q;
        default: readdata_d = '0;
      endcase
    end

    if (wr_acc && rd_acc) readdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  rd_ptr_q <= '0;   wr_ptr_q <= '0;
      count_q <= '0;      idx_q <= '0;      readdata_q <= '0;
      result_q <= '1;     strlen_q <= '0;   key_q <= '0;
      ovf_q <= 1'b0;      udf_q <= 1'b0;    berr_q <= 1'b0;
      match_q <= 1'b0;    cf_q <= 1'b0;
    end else begin
      state_q <= state_d;   rd_ptr_q <= rd_ptr_d; wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;   idx_q <= idx_d;       readdata_q <= readdata_d;
      result_q <= result_d; strlen_q <= strlen_d; key_q <= key_d;
      ovf_q <= ovf_d;       udf_q <= udf_d;       berr_q <= berr_d;
      match_q <= match_d;   cf_q <= cf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= bus.writedata;
  end
endmodule

// File: tb/tb_string_fifo_scan_avalon.sv
// Directed self-checking bench for string_fifo_scan_avalon at DEPTH=4.
module tb_string_fifo_scan_avalon;
  localparam logic [31:0] W_ABCD = 32'h61626364;  // "abcd"
  localparam logic [31:0] W_1234 = 32'h31323334;
  localparam logic [31:0] W_5678 = 32'h35363738;
  localparam logic [31:0] W_HELL = 32'h68656C6C;  // "hell"
  localparam logic [31:0] W_O0XY = 32'h6F007879;  // "o\0xy"
  localparam logic [31:0] W_CCCC = 32'h63636363;
  localparam logic [31:0] W_DDDD = 32'h64646464;
  localparam logic [31:0] W_EEEE = 32'h65656565;
  localparam logic [31:0] W_FF0F = 32'h66660066;  // "ff\0f"
  localparam logic [31:0] W_KKKK = 32'h6B6B6B6B;
  localparam logic [31:0] W_ABcd = 32'h41426364;  // "ABcd"

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned busy_cnt;

  string_fifo_scan_avalon_if bus ();
  string_fifo_scan_avalon #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
    bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic wait_idle(output logic [31:0] st);
    st = 32'h10;
    for (int i = 0; i < 20; i++) begin
      bus_read(3'd1, st);
      if (!st[4]) break;
    end
    check("scan_done", {31'b0, st[4]}, 32'h0);
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.readdata, 32'h0);
    reset = 1'b0;

    bus_read(3'd1, rd); check("rst_status", rd, 32'h00000001);
    bus_read(3'd4, rd); check("rst_result", rd, 32'hFFFFFFFF);
    bus_read(3'd5, rd); check("rst_strlen", rd, 32'h0);
    bus_read(3'd3, rd); check("rst_key", rd, 32'h0);

    // Basic FIFO order
    bus_write(3'd0, W_ABCD); bus_write(3'd0, W_1234); bus_write(3'd0, W_5678);
    bus_read(3'd1, rd); check("st_cnt3", rd, 32'h00030000);
    bus_read(3'd0, rd); check("pop0", rd, W_ABCD);
    bus_read(3'd0, rd); check("pop1", rd, W_1234);
    bus_read(3'd0, rd); check("pop2", rd, W_5678);
    bus_read(3'd1, rd); check("st_empty", rd, 32'h00000001);

    // Overflow / underflow / sticky clear
    for (int i = 0; i < 5; i++) bus_write(3'd0, 32'h100 + 32'(i));
    bus_read(3'd1, rd); check("st_ovf", rd, 32'h00040006);
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd0, rd); check("pop_full", rd, 32'h100 + 32'(i));
    end
    bus_read(3'd0, rd); check("pop_udf", rd, 32'h0);
    bus_read(3'd1, rd); check("st_udf", rd, 32'h0000000D);
    bus_write(3'd2, 32'h4);
    bus_read(3'd1, rd); check("st_stclr", rd, 32'h00000001);

    // Scan "hell","o\0xy" with KEY='o', busy window observed by back-to-back STATUS reads
    bus_write(3'd0, W_HELL); bus_write(3'd0, W_O0XY);
    bus_write(3'd3, 32'h6F);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd2; bus.writedata = 32'h2;
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b1; bus.address = 3'd1;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd = bus.readdata;
      if (rd[4]) busy_cnt++;
    end
    bus.chipselect = 1'b0; bus.read = 1'b0;
    check("busy_cycles", busy_cnt, 32'd3);
    check("scan_status", rd, 32'h00020020);
    bus_read(3'd4, rd); check("hello_result", rd, 32'd4);
    bus_read(3'd5, rd); check("hello_strlen", rd, 32'd5);
    bus_read(3'd0, rd); check("nondestr_pop", rd, W_HELL);
    bus_write(3'd2, 32'h1);

    // No match, no NUL; then KEY=0 on the same data
    bus_write(3'd0, W_ABCD);
    bus_write(3'd3, 32'h7A);
    bus_write(3'd2, 32'h2);
    wait_idle(rd);
    check("nomatch_status", rd, 32'h00010000);
    bus_read(3'd4, rd); check("nomatch_result", rd, 32'hFFFFFFFF);
    bus_read(3'd5, rd); check("nomatch_strlen", rd, 32'd4);
    bus_write(3'd3, 32'h0);
    bus_write(3'd2, 32'h2);
    wait_idle(rd);
    bus_read(3'd4, rd); check("key0_result", rd, 32'hFFFFFFFF);

    // Held read pops twice
    bus_write(3'd2, 32'h1);
    bus_write(3'd0, W_1234); bus_write(3'd0, W_5678);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 3'd0;
    @(negedge clk); rd = bus.readdata; check("hold_pop0", rd, W_1234);
    @(negedge clk); rd = bus.readdata; check("hold_pop1", rd, W_5678);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    bus_read(3'd1, rd); check("hold_empty", rd, 32'h00000001);

    // Simultaneous write+read: push happens, readdata forced to 0
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b1;
    bus.address = 3'd0; bus.writedata = W_ABCD;
    @(negedge clk);
    rd = bus.readdata; check("wr_rd_data", rd, 32'h0);
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus_read(3'd1, rd); check("wr_rd_count", rd, 32'h00010000);

    // DATA read while busy
    bus_write(3'd0, W_1234);
    bus_write(3'd2, 32'h2);
    bus_read(3'd0, rd); check("busy_pop", rd, 32'h0);
    wait_idle(rd);
    check("busy_err_st", rd, 32'h00020040);
    bus_write(3'd2, 32'h5);

    // Wrap-around scan in FIFO order
    bus_write(3'd0, W_ABCD); bus_write(3'd0, W_1234); bus_write(3'd0, W_CCCC);
    bus_read(3'd0, rd); check("wrap_pop0", rd, W_ABCD);
    bus_read(3'd0, rd); check("wrap_pop1", rd, W_1234);
    bus_write(3'd0, W_DDDD); bus_write(3'd0, W_EEEE); bus_write(3'd0, W_FF0F);
    bus_write(3'd3, 32'h65);
    bus_write(3'd2, 32'h2);
    wait_idle(rd);
    check("wrap_status", rd, 32'h00040022);
    bus_read(3'd4, rd); check("wrap_result", rd, 32'd8);
    bus_read(3'd5, rd); check("wrap_strlen", rd, 32'd14);
    bus_read(3'd0, rd); check("wrap_q0", rd, W_CCCC);
    bus_read(3'd0, rd); check("wrap_q1", rd, W_DDDD);
    bus_read(3'd0, rd); check("wrap_q2", rd, W_EEEE);
    bus_read(3'd0, rd); check("wrap_q3", rd, W_FF0F);

    // Clear mid-scan after a match was already recorded
    for (int i = 0; i < 4; i++) bus_write(3'd0, W_KKKK);
    bus_write(3'd3, 32'h6B);
    bus_write(3'd2, 32'h2);
    bus_write(3'd2, 32'h1);
    bus_read(3'd1, rd); check("abort_status", rd, 32'h00000001);
    bus_read(3'd4, rd); check("abort_result", rd, 32'hFFFFFFFF);
    bus_read(3'd5, rd); check("abort_strlen", rd, 32'h0);

    // Casefold mode
    bus_write(3'd0, W_ABcd);
    bus_write(3'd3, 32'h62);
    bus_write(3'd2, 32'h8);
`ifdef STRFIFO_CASEFOLD_EN
    bus_read(3'd1, rd); check("cf_status", rd, 32'h00010080);
`else
    bus_read(3'd1, rd); check("cf_status", rd, 32'h00010000);
`endif
    bus_write(3'd2, 32'hA);
    wait_idle(rd);
`ifdef STRFIFO_CASEFOLD_EN
    bus_read(3'd4, rd); check("cf_result", rd, 32'd1);
`else
    bus_read(3'd4, rd); check("cf_result", rd, 32'hFFFFFFFF);
`endif
    bus_read(3'd5, rd); check("cf_strlen", rd, 32'd4);
    bus_read(3'd6, rd); check("reserved_rd", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
